// File: rtl/serial_word_feeder_pkg.sv
// Shared types and helpers for the serial word feeder.
package serial_feeder_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Downstream shift direction encoding (matches the shift register's dir input).
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Width of a counter that must hold values 0..max_count without wrapping.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/serial_word_feeder_bit_tick_gen.sv
// Bit-period divider: produces a one-cycle tick at the end of every
// CLKS_PER_BIT-cycle bit period while not held in clear.
module bit_tick_gen
  import serial_feeder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DW = cnt_width(CLKS_PER_BIT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

  logic [DW-1:0] div_cnt;

  // Tick on the last cycle of a bit period; suppressed while cleared so an
  // idle feeder never strobes.
  assign tick = !clear && (div_cnt == DIV_LAST);

  // Divider counter: restarts on clear or at the end of each bit period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for a left/right shift register: accepts a word
// over valid/ready and emits it one bit per bit period with a shift strobe.
module serial_word_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             ser_out,
  output logic             ser_en,
  output logic             ser_dir,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic             dir_q;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             tick;
  logic             div_clear;
  logic             last_bit;
  logic             last_gap;

  // The divider only runs while a frame or gap is in progress, so each
  // frame starts with a full bit period after the accept edge.
  assign div_clear = (state == IDLE);

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_tick (
    .clk  (clk),
    .reset(reset),
    .clear(div_clear),
    .tick (tick)
  );

  assign last_bit = tick && (bit_cnt == BIT_LAST);
  assign last_gap = tick && (gap_cnt == GAP_LAST);
  assign ser_dir  = dir_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept, shift WIDTH bits, optional idle gap.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_next = (GAP_BITS > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (last_gap) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the current state and bit-period tick.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b1;
    ser_en     = 1'b0;
    ser_out    = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      SHIFT: begin
        ser_out    = (dir_q == DIR_LEFT) ? shreg[WIDTH-1] : shreg[0];
        ser_en     = tick;
        frame_done = last_bit;
      end
      GAP: begin
        ser_out = 1'b0;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath: latch the word on accept, shift on every strobe, count gap periods.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      dir_q   <= DIR_LEFT;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shreg   <= in_data;
            dir_q   <= in_msb_first;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (dir_q == DIR_LEFT) begin
              shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
              shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        GAP: begin
          if (tick) gap_cnt <= gap_cnt + GW'(1);
        end
        default: begin
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Self-checking bench: two feeder instances (1 and 3 clocks per bit) checked
// every cycle against a frame-timeline model, each driving a modelled
// downstream 4-bit left/right shift register.
module tb_serial_word_feeder;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid [2];
  logic [3:0] in_data  [2];
  logic       in_msb   [2];
  logic       ready_s  [2];
  logic       out_s    [2];
  logic       en_s     [2];
  logic       dir_s    [2];
  logic       busy_s   [2];
  logic       done_s   [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: frame active, cycle index since accept edge.
  bit         m_act  [2];
  int         m_n    [2];
  logic [3:0] m_word [2];
  logic       m_msb  [2];
  logic       m_dir  [2];
  // Downstream register and capture of the emitted bit stream.
  logic [3:0] q        [2];
  logic [3:0] cap      [2];
  logic [3:0] last_q   [2];
  logic [3:0] last_cap [2];
  int         strobes  [2];
  int         last_strb[2];
  int         frames   [2];

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(4), .CLKS_PER_BIT(1), .GAP_BITS(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(ready_s[0]),
    .in_data(in_data[0]), .in_msb_first(in_msb[0]), .ser_out(out_s[0]),
    .ser_en(en_s[0]), .ser_dir(dir_s[0]), .busy(busy_s[0]), .frame_done(done_s[0])
  );

  serial_word_feeder #(.WIDTH(4), .CLKS_PER_BIT(3), .GAP_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(ready_s[1]),
    .in_data(in_data[1]), .in_msb_first(in_msb[1]), .ser_out(out_s[1]),
    .ser_en(en_s[1]), .ser_dir(dir_s[1]), .busy(busy_s[1]), .frame_done(done_s[1])
  );

  function automatic int cpb(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int gapb(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the frame timeline, then advance the model.
  always @(negedge clk) begin
    int c, tot, bi;
    logic e_rdy, e_busy, e_en, e_out, e_dir, e_done;
    for (int i = 0; i < 2; i++) begin
      c   = cpb(i);
      tot = (W + gapb(i)) * c;
      e_rdy = 1'b1; e_busy = 1'b0; e_en = 1'b0; e_out = 1'b0; e_done = 1'b0;
      e_dir = m_dir[i];
      if (reset) begin
        e_dir = 1'b1;
      end else if (m_act[i]) begin
        e_rdy  = 1'b0;
        e_busy = 1'b1;
        if (m_n[i] <= W * c) begin
          bi     = (m_n[i] - 1) / c;
          e_out  = m_msb[i] ? m_word[i][W-1-bi] : m_word[i][bi];
          e_en   = (m_n[i] % c) == 0;
          e_done = (m_n[i] == W * c);
        end
      end
      chk("in_ready", i, ready_s[i], e_rdy);
      chk("busy", i, busy_s[i], e_busy);
      chk("ser_en", i, en_s[i], e_en);
      chk("ser_out", i, out_s[i], e_out);
      chk("ser_dir", i, dir_s[i], e_dir);
      chk("frame_done", i, done_s[i], e_done);

      // Downstream shift register fed by the DUT outputs.
      if (en_s[i] === 1'b1) begin
        q[i]   = dir_s[i] ? {q[i][2:0], out_s[i]} : {out_s[i], q[i][3:1]};
        cap[i] = {cap[i][2:0], out_s[i]};
        strobes[i]++;
      end
      if (e_done) begin
        chk("frame_q", i, q[i], m_word[i]);
        last_q[i]    = q[i];
        last_cap[i]  = cap[i];
        last_strb[i] = strobes[i];
        frames[i]++;
      end

      if (reset) begin
        m_act[i] = 1'b0;
        m_dir[i] = 1'b1;
      end else if (!m_act[i]) begin
        if (in_valid[i]) begin
          m_act[i]   = 1'b1;
          m_n[i]     = 1;
          m_word[i]  = in_data[i];
          m_msb[i]   = in_msb[i];
          m_dir[i]   = in_msb[i];
          q[i]       = 4'h0;
          cap[i]     = 4'h0;
          strobes[i] = 0;
        end
      end else if (m_n[i] == tot) begin
        m_act[i] = 1'b0;
      end else begin
        m_n[i]++;
      end
    end
  end

  // Offer a word, wait for acceptance, then count edges until in_ready returns.
  task automatic send_check(input int i, input logic [3:0] w, input logic m,
                            input logic [3:0] exp_cap, input int exp_lat);
    int k, lat, f0;
    in_valid[i] = 1'b1; in_data[i] = w; in_msb[i] = m;
    k = 0;
    while (ready_s[i] !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
    if (k >= 200) chk("accept_timeout", i, 0, 1);
    f0 = frames[i];
    @(posedge clk); #1;
    in_valid[i] = 1'b0; in_data[i] = 4'($urandom); in_msb[i] = 1'($urandom);
    lat = 0;
    while (ready_s[i] !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("ready_latency", i, lat, exp_lat);
    chk("frame_count", i, frames[i], f0 + 1);
    chk("bit_sequence", i, last_cap[i], exp_cap);
    chk("strobe_count", i, last_strb[i], 4);
    chk("downstream_q", i, last_q[i], w);
    $display("txn inst=%0d word=%b msb_first=%0d bits=%b q=%b latency=%0d",
             i, w, m, last_cap[i], last_q[i], lat);
  endtask

  task automatic wait_frame(input int i);
    int f0, k;
    f0 = frames[i]; k = 0;
    while (frames[i] == f0 && k < 300) begin @(posedge clk); #1; k++; end
    if (frames[i] == f0) chk("frame_timeout", i, 0, 1);
  endtask

  initial begin
    int k, f0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = 4'h0; in_msb[i] = 1'b0;
      m_act[i] = 1'b0; m_n[i] = 0; m_word[i] = 4'h0; m_msb[i] = 1'b1; m_dir[i] = 1'b1;
      q[i] = 4'h0; cap[i] = 4'h0; last_q[i] = 4'h0; last_cap[i] = 4'h0;
      strobes[i] = 0; last_strb[i] = 0; frames[i] = 0;
    end

    // Reset held for 3 cycles, then literal reset-state checks.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", i, ready_s[i], 1'b1);
      chk("rst_ser_en", i, en_s[i], 1'b0);
      chk("rst_ser_dir", i, dir_s[i], 1'b1);
      chk("rst_ser_out", i, out_s[i], 1'b0);
      chk("rst_busy", i, busy_s[i], 1'b0);
    end

    // Directed frames with hand-computed bit order and latency.
    send_check(0, 4'b1011, 1'b1, 4'b1011, 5);
    send_check(0, 4'b0110, 1'b0, 4'b0110, 5);
    send_check(1, 4'b1001, 1'b1, 4'b1001, 18);
    send_check(1, 4'b0011, 1'b0, 4'b1100, 18);

    // Back-to-back with in_valid held: second word waits for in_ready.
    in_valid[0] = 1'b1; in_data[0] = 4'hA; in_msb[0] = 1'b1;
    @(posedge clk); #1;
    in_data[0] = 4'h5;
    wait_frame(0);
    chk("b2b_first_q", 0, last_q[0], 4'hA);
    k = 0;
    while (ready_s[0] !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_frame(0);
    chk("b2b_second_q", 0, last_q[0], 4'h5);
    $display("txn inst=0 back-to-back words A,5 q=%h", last_q[0]);

    // Reset after the second strobe of a frame.
    k = 0;
    while (ready_s[0] !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    in_valid[0] = 1'b1; in_data[0] = 4'b1110; in_msb[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    k = 0;
    while (strobes[0] < 2 && k < 50) begin @(posedge clk); #1; k++; end
    f0 = frames[0];
    reset = 1'b1;
    #1 chk("abort_ser_en", 0, en_s[0], 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_no_done", 0, frames[0], f0);
    chk("abort_in_ready", 0, ready_s[0], 1'b1);
    $display("txn inst=0 aborted frame 1110 after %0d strobes", strobes[0]);
    send_check(0, 4'b0101, 1'b0, 4'b1010, 5);

    // Randomised traffic on both instances with occasional resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = ($urandom_range(0, 2) != 0);
        in_data[i]  = 4'($urandom);
        in_msb[i]   = 1'($urandom);
      end
      reset = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("random phase frames completed: inst0=%0d inst1=%0d", frames[0], frames[1]);
    if (frames[0] < 10 || frames[1] < 5) chk("random_frames", 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
Upstream parallel-to-serial stage that drives the 4-bit left/right shift register. It accepts a parallel word over a valid/ready handshake and emits it one bit per bit period. Outputs are a serial data bit, a one-cycle shift-enable strobe and a direction flag, which connect directly to the shift register's serial_in, shift_en and dir. After WIDTH strobes, the downstream register holds the original word exactly, for either bit order.

Parameters:
WIDTH, 4, word width; must equal the downstream register width; >=2
CLKS_PER_BIT, 1, clock cycles per serial bit period; >=1
GAP_BITS, 1, idle bit periods inserted after each frame; >=0

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream word valid
in_ready  out  1  block can accept a word
in_data  in  WIDTH  word to serialise
in_msb_first  in  1  1 = MSB first / downstream shifts left; 0 = LSB first / downstream shifts right
ser_out  out  1  serial bit to downstream serial_in
ser_en  out  1  one-cycle shift strobe to downstream shift_en
ser_dir  out  1  direction to downstream dir
busy  out  1  frame or gap in progress
frame_done  out  1  one-cycle pulse coincident with the last ser_en of a frame

Behaviour:
- Reset is clk (rising edge) and reset (asynchronous, active-high).
- Reset values: state IDLE; shift reg 0; ser_out 0; ser_en 0; ser_dir 1; frame_done 0; busy 0; in_ready 1; all counters 0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1, busy=0, ser_en=0, ser_out=0.
  - On an edge with in_valid&&in_ready: latch in_data into the shift reg, latch in_msb_first into dir_q, clear bit_cnt and div_cnt, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - ser_out = dir_q ? shreg[WIDTH-1] : shreg[0]; held stable for the whole bit period.
  - div_cnt counts 0..CLKS_PER_BIT-1. ser_en=1 only in the cycle where div_cnt==CLKS_PER_BIT-1, so the downstream register samples ser_out on that edge.
  - On that same edge: shreg shifts (left if dir_q, else right, zero fill), bit_cnt increments, div_cnt clears.
  - When the strobe has bit_cnt==WIDTH-1: frame_done=1 in that cycle. Next state is GAP if GAP_BITS>0, else IDLE.
  - With CLKS_PER_BIT=1, ser_en is high for WIDTH consecutive cycles.
- GAP:
  - ser_out=0, ser_en=0, busy=1, in_ready=0.
  - Lasts exactly GAP_BITS*CLKS_PER_BIT cycles, then IDLE.
- ser_dir = dir_q. It updates on acceptance (visible the cycle after the accept edge, before the first ser_en) and holds through the gap and the following IDLE.
- Latency: the first ser_en is the cycle CLKS_PER_BIT after the accept edge. in_ready reasserts (WIDTH+GAP_BITS)*CLKS_PER_BIT cycles after the accept edge. Sustained throughput is one word per 1+(WIDTH+GAP_BITS)*CLKS_PER_BIT cycles.
- in_valid while busy: not accepted, no side effects. in_data and in_msb_first changes mid-frame are ignored.
- Reset mid-frame: immediate abort to reset values; no frame_done, no further ser_en.
- Counter widths are $clog2 of their maximum count plus 1; no wrap inside a frame.
- Downstream correctness: with ser_dir driving dir, after the frame the downstream q equals in_data. MSB-first with left shift leaves in_data[WIDTH-1] at q[WIDTH-1]. LSB-first with right shift leaves in_data[0] at q[0].

Decomposition:
- Package serial_feeder_pkg holds: the state enum (IDLE/SHIFT/GAP), the DIR_LEFT=1 / DIR_RIGHT=0 constants, and a function for counter width.
- One sub-module, bit_tick_gen: a CLKS_PER_BIT divider with a synchronous clear that produces the end-of-bit-period tick. The FSM and shift register stay in the top module.

Test Plan:
- Reset: hold reset 3 cycles, then release -> in_ready=1, ser_en=0, ser_dir=1, ser_out=0, busy=0.
- WIDTH=4, CLKS_PER_BIT=1, GAP_BITS=1: send 4'b1011 with msb_first=1 -> ser_en high 4 cycles carrying bits 1,0,1,1; frame_done on the 4th; connected shift register q=4'b1011; in_ready back 5 cycles after accept.
- Send 4'b0110 with msb_first=0 -> ser_dir=0 before the first strobe; bits 0,1,1,0; downstream q=4'b0110.
- CLKS_PER_BIT=3: send 4'b1001 -> ser_en every 3rd cycle; ser_out held 3 cycles per bit; 4 strobes total; q=4'b1001.
- Back-to-back: in_valid held high with 4'hA then 4'h5 -> the second word is accepted only when in_ready=1; no overlap; q=4'hA, then 4'h5.
- Reset asserted after the 2nd strobe of a frame -> ser_en stops immediately; no frame_done; in_ready=1 after release; a new word is serialised correctly.
